// File: rtl/bist_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : bist_scheduler
// Brief   : Round-robin arbiter sharing one BIST engine among NUM_CLIENTS
//           requesters, with a start pulse, completion tracking and watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module bist_scheduler #(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = $clog2(NUM_CLIENTS),
    parameter int TIMEOUT     = 1000,
    parameter int TO_W        = $clog2(TIMEOUT + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [IDX_W-1:0]       sel,
    output logic                   busy,
    output logic                   bist_start,
    input  logic                   bist_init,
    input  logic                   bist_running,
    input  logic                   bist_finish,
    input  logic                   bist_end,
    output logic                   engine_abort,
    output logic [NUM_CLIENTS-1:0] done,
    output logic [NUM_CLIENTS-1:0] timeout
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_INIT = 3'd2,
        S_RUN       = 3'd3,
        S_RELEASE   = 3'd4,
        S_ABORT     = 3'd5
    } state_t;

    localparam logic [TO_W-1:0]  C_TIMEOUT = TO_W'(TIMEOUT);
    localparam logic [IDX_W:0]   C_N       = (IDX_W + 1)'(NUM_CLIENTS);
    localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(NUM_CLIENTS - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [IDX_W-1:0]         r_rr_ptr;
    logic [TO_W-1:0]          r_wd;
    logic                     w_wd_expired;
    logic [IDX_W:0]           w_cand;
    logic                     w_win_found;
    logic [IDX_W-1:0]         w_win_idx;
    logic [IDX_W-1:0]         w_rr_next;
    logic [NUM_CLIENTS-1:0]   r_grant;
    logic [IDX_W-1:0]         r_sel;
    logic                     r_busy;
    logic                     r_bist_start;
    logic                     r_engine_abort;
    logic [NUM_CLIENTS-1:0]   r_done;
    logic [NUM_CLIENTS-1:0]   r_timeout;

    // Engine status lines are observed by software only.
    wire w_unused = &{1'b0, bist_running, bist_finish};

    assign w_wd_expired = (r_wd == C_TIMEOUT);
    assign w_rr_next    = (r_sel == C_LAST) ? '0 : r_sel + IDX_W'(1);

    // Scan offsets from farthest to nearest so the nearest hit past rr_ptr wins.
    always_comb begin
        w_cand      = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
            if (w_cand >= C_N) begin
                w_cand = w_cand - C_N;
            end
            if (req[w_cand[IDX_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_win_found) w_next_state = S_START;
            S_START:     w_next_state = S_WAIT_INIT;
            S_WAIT_INIT: begin
                if (bist_init)         w_next_state = S_RUN;
                else if (w_wd_expired) w_next_state = S_ABORT;
            end
            // Completion takes priority over a coincident watchdog expiry.
            S_RUN: begin
                if (bist_end)          w_next_state = S_RELEASE;
                else if (w_wd_expired) w_next_state = S_ABORT;
            end
            S_RELEASE:   w_next_state = S_IDLE;
            S_ABORT:     w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr       <= '0;
            r_wd           <= '0;
            r_grant        <= '0;
            r_sel          <= '0;
            r_busy         <= 1'b0;
            r_bist_start   <= 1'b0;
            r_engine_abort <= 1'b0;
            r_done         <= '0;
            r_timeout      <= '0;
        end else begin
            r_busy         <= (w_next_state != S_IDLE);
            r_bist_start   <= (w_next_state == S_START);
            r_engine_abort <= (w_next_state == S_ABORT);
            r_done         <= '0;
            r_timeout      <= '0;

            if (r_state == S_START) begin
                r_wd <= '0;
            end else if ((r_state == S_WAIT_INIT || r_state == S_RUN) && !w_wd_expired) begin
                r_wd <= r_wd + TO_W'(1);
            end

            if (r_state == S_IDLE && w_next_state == S_START) begin
                r_grant <= NUM_CLIENTS'(1) << w_win_idx;
                r_sel   <= w_win_idx;
            end else if (w_next_state == S_RELEASE || w_next_state == S_ABORT) begin
                // r_grant is the one-hot image of r_sel, so it marks the client bit.
                if (w_next_state == S_RELEASE) r_done    <= r_grant;
                else                           r_timeout <= r_grant;
                r_grant  <= '0;
                r_sel    <= '0;
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign grant        = r_grant;
    assign sel          = r_sel;
    assign busy         = r_busy;
    assign bist_start   = r_bist_start;
    assign engine_abort = r_engine_abort;
    assign done         = r_done;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bist_scheduler.sv
`default_nettype none
// Directed, table-driven bench for bist_scheduler (4 clients, TIMEOUT=20).
module tb_bist_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       bist_start;
    logic       bist_init;
    logic       bist_running;
    logic       bist_finish;
    logic       bist_end;
    logic       engine_abort;
    logic [3:0] done;
    logic [3:0] timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  req;
        logic        init;
        logic        en;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    bist_scheduler #(
        .NUM_CLIENTS(4),
        .TIMEOUT    (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .sel         (sel),
        .busy        (busy),
        .bist_start  (bist_start),
        .bist_init   (bist_init),
        .bist_running(bist_running),
        .bist_finish (bist_finish),
        .bist_end    (bist_end),
        .engine_abort(engine_abort),
        .done        (done),
        .timeout     (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [16:0] pack(input logic [3:0] g, input logic [1:0] s,
                                         input logic b, input logic st, input logic a,
                                         input logic [3:0] d, input logic [3:0] t);
        return {g, s, b, st, a, d, t};
    endfunction

    function automatic void add(input string nm, input logic [3:0] r, input logic i,
                                input logic e, input logic [16:0] x);
        vecs.push_back('{r, i, e, x, nm});
    endfunction

    task automatic check(input string nm, input logic [16:0] exp);
        logic [16:0] act;
        act = {grant, sel, busy, bist_start, engine_abort, done, timeout};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got grant=%b sel=%b busy=%b start=%b abort=%b done=%b timeout=%b, need grant=%b sel=%b busy=%b start=%b abort=%b done=%b timeout=%b",
                     nm, act[16:13], act[12:11], act[10], act[9], act[8], act[7:4], act[3:0],
                     exp[16:13], exp[12:11], exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    // Drive inputs just after an edge, then advance to 1ns past the next edge.
    task automatic step(input logic [3:0] r, input logic i, input logic e);
        req       = r;
        bist_init = i;
        bist_end  = e;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got running, need finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        logic [1:0] s;
        int         to_cycles;

        // Single client, then req=1111 round robin starting from rr_ptr=1.
        add("t1_start",   4'b0001, 1'b0, 1'b0, pack(4'b0001, 2'd0, 1, 1, 0, 4'b0000, 4'b0000));
        add("t1_winit",   4'b0001, 1'b0, 1'b0, pack(4'b0001, 2'd0, 1, 0, 0, 4'b0000, 4'b0000));
        add("t1_run",     4'b0001, 1'b1, 1'b0, pack(4'b0001, 2'd0, 1, 0, 0, 4'b0000, 4'b0000));
        add("t1_run2",    4'b0001, 1'b0, 1'b0, pack(4'b0001, 2'd0, 1, 0, 0, 4'b0000, 4'b0000));
        add("t1_release", 4'b0001, 1'b0, 1'b1, pack(4'b0000, 2'd0, 1, 0, 0, 4'b0001, 4'b0000));
        add("t1_idle",    4'b0000, 1'b0, 1'b0, pack(4'b0000, 2'd0, 0, 0, 0, 4'b0000, 4'b0000));
        add("t1_idle2",   4'b0000, 1'b0, 1'b0, pack(4'b0000, 2'd0, 0, 0, 0, 4'b0000, 4'b0000));
        for (int n = 0; n < 5; n++) begin
            s = 2'((1 + n) % 4);
            g = 4'b0001 << s;
            add("rr_start",   4'b1111, 1'b0, 1'b0, pack(g, s, 1, 1, 0, 4'b0000, 4'b0000));
            add("rr_winit",   4'b1111, 1'b0, 1'b0, pack(g, s, 1, 0, 0, 4'b0000, 4'b0000));
            add("rr_run",     4'b1111, 1'b1, 1'b0, pack(g, s, 1, 0, 0, 4'b0000, 4'b0000));
            add("rr_release", 4'b1111, 1'b0, 1'b1, pack(4'b0000, 2'd0, 1, 0, 0, g, 4'b0000));
            add("rr_idle",    4'b1111, 1'b0, 1'b0, pack(4'b0000, 2'd0, 0, 0, 0, 4'b0000, 4'b0000));
        end

        reset        = 1'b0;
        req          = '0;
        bist_init    = 1'b0;
        bist_running = 1'b0;
        bist_finish  = 1'b0;
        bist_end     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset", pack(4'b0000, 2'd0, 0, 0, 0, 4'b0000, 4'b0000));
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].init, vecs[i].en);
            check(vecs[i].name, vecs[i].exp);
        end

        // Watchdog: rr_ptr=2, engine never responds.
        step(4'b1100, 1'b0, 1'b0);
        check("to_start", pack(4'b0100, 2'd2, 1, 1, 0, 4'b0000, 4'b0000));
        to_cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            step(4'b1100, 1'b0, 1'b0);
            if (timeout != 4'b0000 || engine_abort) begin
                to_cycles = k;
                break;
            end
        end
        n_checks++;
        if (to_cycles != 22) begin
            n_fail++;
            $display("FAIL to_latency: abort at step %0d after start, need step 22", to_cycles);
        end
        check("to_abort", pack(4'b0000, 2'd0, 1, 0, 1, 4'b0000, 4'b0100));
        step(4'b1100, 1'b0, 1'b0);
        check("to_idle", pack(4'b0000, 2'd0, 0, 0, 0, 4'b0000, 4'b0000));

        // Next requester after abort; bist_end lands exactly as watchdog hits TIMEOUT.
        step(4'b1100, 1'b0, 1'b0);
        check("co_start", pack(4'b1000, 2'd3, 1, 1, 0, 4'b0000, 4'b0000));
        for (int j = 1; j <= 21; j++) begin
            step(4'b1100, (j == 3), 1'b0);
        end
        check("co_pre", pack(4'b1000, 2'd3, 1, 0, 0, 4'b0000, 4'b0000));
        step(4'b1100, 1'b0, 1'b1);
        check("co_done", pack(4'b0000, 2'd0, 1, 0, 0, 4'b1000, 4'b0000));
        step(4'b0000, 1'b0, 1'b0);
        check("co_idle", pack(4'b0000, 2'd0, 0, 0, 0, 4'b0000, 4'b0000));

        // Request dropped mid-run still completes; rr_ptr moves to 3.
        step(4'b0100, 1'b0, 1'b0);
        check("dr_start", pack(4'b0100, 2'd2, 1, 1, 0, 4'b0000, 4'b0000));
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("dr_run", pack(4'b0100, 2'd2, 1, 0, 0, 4'b0000, 4'b0000));
        step(4'b0000, 1'b0, 1'b1);
        check("dr_done", pack(4'b0000, 2'd0, 1, 0, 0, 4'b0100, 4'b0000));
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1001, 1'b0, 1'b0);
        check("dr_next", pack(4'b1000, 2'd3, 1, 1, 0, 4'b0000, 4'b0000));
        step(4'b1001, 1'b0, 1'b0);
        step(4'b1001, 1'b1, 1'b0);
        check("ar_run", pack(4'b1000, 2'd3, 1, 0, 0, 4'b0000, 4'b0000));

        // Asynchronous reset in RUN, mid-cycle.
        #3;
        reset = 1'b0;
        #1;
        check("ar_async", pack(4'b0000, 2'd0, 0, 0, 0, 4'b0000, 4'b0000));
        @(posedge clock);
        #1;
        check("ar_held", pack(4'b0000, 2'd0, 0, 0, 0, 4'b0000, 4'b0000));
        reset = 1'b1;
        step(4'b1010, 1'b0, 1'b0);
        check("ar_regrant", pack(4'b0010, 2'd1, 1, 1, 0, 4'b0000, 4'b0000));
        step(4'b1010, 1'b0, 1'b0);
        step(4'b1010, 1'b1, 1'b0);
        step(4'b1010, 1'b0, 1'b1);
        check("ar_done", pack(4'b0000, 2'd0, 1, 0, 0, 4'b0010, 4'b0000));
        step(4'b0000, 1'b0, 1'b0);
        check("ar_idle", pack(4'b0000, 2'd0, 0, 0, 0, 4'b0000, 4'b0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
